// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the A09 fetch path: PC source select and branch offset
// source. SequenceControl drives these strobes and the fetch unit decodes them.
package fetch_unit_pkg;

    // PC load source select
    typedef enum logic [1:0] {
        PC_SRC_REL = 2'b00,  // PC + sign-extended branch offset
        PC_SRC_STK = 2'b01,  // return-stack register
        PC_SRC_ABS = 2'b10,  // absolute target from the register file
        PC_SRC_VEC = 2'b11   // reset/interrupt vector 0
    } pc_src_e;

    // Branch offset source select
    localparam logic BRA_SRC_IR  = 1'b0;  // sext(IR[7:0])
    localparam logic BRA_SRC_REG = 1'b1;  // RegData[AddrWidth-1:0]

    // Width of the immediate offset field inside the instruction word
    localparam int IR_OFFSET_WIDTH = 8;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_branch_target.sv
// Relative branch target: picks the offset, sign-extends the instruction
// immediate to PC width and adds it to the current PC modulo 2^AddrWidth.
module fetch_unit_branch_target
    import fetch_unit_pkg::*;
#(
    parameter int AddrWidth = 8
) (
    input  logic [AddrWidth-1:0]       pc,
    input  logic [IR_OFFSET_WIDTH-1:0] ir_offset,
    input  logic [AddrWidth-1:0]       reg_offset,
    input  logic                       bra_src,
    output logic [AddrWidth-1:0]       target
);

    logic [AddrWidth-1:0] ir_offset_ext;
    logic [AddrWidth-1:0] offset_sel;

    // Bitwise sign extension of the immediate; also truncates cleanly if the
    // PC is ever narrower than the immediate field.
    for (genvar gi = 0; gi < AddrWidth; gi++) begin : g_sext
        if (gi < IR_OFFSET_WIDTH) begin : g_low
            assign ir_offset_ext[gi] = ir_offset[gi];
        end else begin : g_ext
            assign ir_offset_ext[gi] = ir_offset[IR_OFFSET_WIDTH-1];
        end
    end

    // Offset select and modulo add (carry out is dropped intentionally)
    always_comb begin
        offset_sel = (bra_src == BRA_SRC_REG) ? reg_offset : ir_offset_ext;
        target     = pc + offset_sel;
    end

endmodule : fetch_unit_branch_target

// File: rtl/fetch_unit.sv
// A09 instruction fetch and program-counter unit. Executes SequenceControl's
// PC/STK strobes and runs a request/ack memory read into IR on IR_Ld.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 8,
    parameter int WordSize  = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 IR_Ld,
    input  logic                 PC_Rst,
    input  logic                 PC_Inc,
    input  logic                 PC_Ld,
    input  logic [1:0]           PC_Src,
    input  logic                 BRA_Src,
    input  logic                 STK_Ld,
    input  logic                 Halt,
    input  logic [DataWidth-1:0] RegData,
    output logic [AddrWidth-1:0] MEM_Addr,
    output logic                 MEM_Rd,
    input  logic [DataWidth-1:0] MEM_DataIn,
    input  logic                 MEM_Ack,
    output logic [DataWidth-1:0] IR,
    output logic                 IR_Valid,
    output logic                 Busy,
    output logic [AddrWidth-1:0] PC,
    output logic [AddrWidth-1:0] STK
);

    localparam logic [AddrWidth-1:0] PC_STEP = AddrWidth'(WordSize);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DONE  = 2'b10
    } fetch_state_e;

    fetch_state_e         state_reg;
    fetch_state_e         state_next;
    logic [AddrWidth-1:0] fa_reg;
    logic [DataWidth-1:0] ir_reg;
    logic [AddrWidth-1:0] pc_reg;
    logic [AddrWidth-1:0] pc_next;
    logic [AddrWidth-1:0] stk_reg;
    logic [AddrWidth-1:0] stk_next;
    logic [AddrWidth-1:0] rel_target;
    logic [AddrWidth-1:0] reg_addr;
    logic                 fetch_start;

    assign reg_addr    = RegData[AddrWidth-1:0];
    assign fetch_start = (state_reg == ST_IDLE) && IR_Ld && !Halt;

    // Register-file bits above the address width only matter to other units
    if (DataWidth > AddrWidth) begin : g_unused_reg
        logic unused_reg_hi;
        assign unused_reg_hi = ^RegData[DataWidth-1:AddrWidth];
    end

    fetch_unit_branch_target #(
        .AddrWidth (AddrWidth)
    ) u_branch_target (
        .pc         (pc_reg),
        .ir_offset  (ir_reg[IR_OFFSET_WIDTH-1:0]),
        .reg_offset (reg_addr),
        .bra_src    (BRA_Src),
        .target     (rel_target)
    );

    // Fetch FSM state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Fetch FSM next state: IR_Ld only counts in IDLE, so it is never queued
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (fetch_start) state_next = ST_FETCH;
            ST_FETCH: if (MEM_Ack)     state_next = ST_DONE;
            ST_DONE:                   state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    // Fetch FSM outputs decoded from the state register so Reset drops MEM_Rd at once
    always_comb begin
        MEM_Rd   = 1'b0;
        Busy     = 1'b0;
        IR_Valid = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                MEM_Rd = 1'b1;
                Busy   = 1'b1;
            end
            ST_DONE:  IR_Valid = 1'b1;
            default:  ;
        endcase
    end

    // Fetch address latched at start; later PC updates do not disturb the read
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fa_reg <= '0;
        end else if (fetch_start) begin
            fa_reg <= pc_reg;
        end
    end

    // Instruction register captures read data only while a fetch is in flight
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ir_reg <= '0;
        end else if (state_reg == ST_FETCH && MEM_Ack) begin
            ir_reg <= MEM_DataIn;
        end
    end

    // PC next value: reset beats load beats increment; Halt freezes
    always_comb begin
        pc_next = pc_reg;
        if (!Halt) begin
            if (PC_Rst) begin
                pc_next = '0;
            end else if (PC_Ld) begin
                case (pc_src_e'(PC_Src))
                    PC_SRC_REL: pc_next = rel_target;
                    PC_SRC_STK: pc_next = stk_reg;
                    PC_SRC_ABS: pc_next = reg_addr;
                    PC_SRC_VEC: pc_next = '0;
                    default:    pc_next = '0;
                endcase
            end else if (PC_Inc) begin
                pc_next = pc_reg + PC_STEP;
            end
        end
    end

    // Return stack takes the pre-update PC
    always_comb begin
        stk_next = stk_reg;
        if (!Halt && STK_Ld) begin
            stk_next = pc_reg;
        end
    end

    // PC and return-stack registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_reg  <= '0;
            stk_reg <= '0;
        end else begin
            pc_reg  <= pc_next;
            stk_reg <= stk_next;
        end
    end

    assign MEM_Addr = fa_reg;
    assign IR       = ir_reg;
    assign PC       = pc_reg;
    assign STK      = stk_reg;

endmodule : fetch_unit
